parity_frame_tx: RTL and testbench

//   Serial frame transmitter downstream of the 4-bit parity generator. Accepts a data word plus its

---
 rtl/parity_frame_pkg.sv | 27 ++
 rtl/parity_frame_tx_if.sv | 23 ++
 rtl/parity_frame_bit_timer.sv | 32 +++
 rtl/parity_frame_tx.sv | 121 ++++++++++++
 tb/tb_parity_frame_tx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/parity_frame_pkg.sv
// rtl/parity_frame_pkg.sv - shared states, line levels and sizing helpers for the serial frame transmitter
// Optional feature macro: TWO_STOP_EN (two stop bits per frame when defined).
package parity_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;

`ifdef TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    // Width of a counter that walks 0..num_states-1; never narrower than one bit.
    function automatic int cnt_w(input int num_states);
        return (num_states > 1) ? $clog2(num_states) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// rtl/parity_frame_tx_if.sv - word/parity valid-ready handshake into the frame transmitter
interface parity_frame_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_parity,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_parity,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/parity_frame_bit_timer.sv
// rtl/parity_frame_bit_timer.sv - clk-cycle counter that marks the last cycle of each serial bit
module parity_frame_bit_timer
    import parity_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = cnt_w(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign bit_tick = run && last;

    // Held at zero while idle so every frame starts on a clean bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - start/data(LSB first)/parity/stop serial frame transmitter
// Optional feature macro: TWO_STOP_EN (stop phase lasts two bit times when defined).
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_frame_tx_if.slave   bus,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int BIT_STATES = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int BIT_W      = cnt_w(BIT_STATES);

    state_t            state, state_n;
    logic [DATA_W:0]   shift, shift_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic              tx_q, tx_n;
    logic              done_q, done_n;
    logic              ready_q, ready_n;
    logic              bit_tick;
    logic              accept;

    parity_frame_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign accept       = bus.in_valid && ready_q;
    assign bus.in_ready = ready_q;
    assign busy         = ~ready_q;
    assign tx           = tx_q;
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_q    <= TX_IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
            ready_q <= ready_n;
        end
    end

    // The parity bit rides above the data in the shift register, so after DATA_W
    // shifts it sits in bit 0 and PARITY drives tx from the same place as DATA.
    // tx/done/ready are registered from the current state, giving the line one
    // cycle of latency behind the FSM.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        tx_n    = TX_IDLE;
        done_n  = 1'b0;
        ready_n = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready_n = !accept;
                if (accept) begin
                    shift_n = {bus.in_parity, bus.in_data};
                    bit_n   = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                tx_n = START_BIT;
                if (bit_tick) state_n = ST_DATA;
            end
            ST_DATA: begin
                tx_n = shift[0];
                if (bit_tick) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_n   = '0;
                        state_n = ST_PARITY;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                tx_n = shift[0];
                if (bit_tick) state_n = ST_STOP;
            end
            ST_STOP: begin
                tx_n = TX_IDLE;
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_n   = '0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - directed and randomized frame checks against a bit-sequence reference model
module tb_parity_frame_tx;
    import parity_frame_pkg::*;

    localparam int DW    = 4;
    localparam int C     = 4;
    localparam int FRAME = (DW + 2 + STOP_BITS) * C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, done;

    always #5 clk = ~clk;

    parity_frame_tx_if #(.DATA_W(DW)) bus ();

    parity_frame_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Serial bit idx of a frame: start, data LSB first, parity, then stop bit(s).
    function automatic logic model_bit(input logic [DW-1:0] d, input logic p, input int idx);
        if (idx == 0)      return 1'b0;
        if (idx <= DW)     return d[idx-1];
        if (idx == DW + 1) return p;
        return 1'b1;
    endfunction

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic present(input logic [DW-1:0] d, input logic p);
        int n = 0;
        bus.in_data   = d;
        bus.in_parity = p;
        bus.in_valid  = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input logic p, input bit hold, input int pulse_k);
        check("accept_ready", bus.in_ready, 1'b0);
        check("accept_tx", tx, 1'b1);
        check("accept_busy", busy, 1'b1);
        if (!hold) bus.in_valid = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check("frame_tx", tx, model_bit(d, p, (k - 1) / C));
            check("frame_done", done, 1'(k == FRAME));
            check("frame_busy", busy, 1'b1);
            if (k == pulse_k) begin
                bus.in_valid  = 1'b1;
                bus.in_data   = ~d;
                bus.in_parity = ~p;
            end else if (k == pulse_k + 1) begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic idle_after;
        @(negedge clk);
        check("gap_tx", tx, 1'b1);
        check("gap_done", done, 1'b0);
        check("gap_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          rp;

        bus.in_data   = '0;
        bus.in_parity = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;

        // Quiet line after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("quiet_tx", tx, 1'b1);
            check("quiet_ready", bus.in_ready, 1'b1);
            check("quiet_busy", busy, 1'b0);
            check("quiet_done", done, 1'b0);
        end

        present(4'b0011, 1'b0);
        run_frame(4'b0011, 1'b0, 1'b0, -1);
        idle_after();

        present(4'b0111, 1'b1);
        run_frame(4'b0111, 1'b1, 1'b0, -1);
        idle_after();

        // Back-to-back with in_valid held; next word staged during the first frame
        present(4'b0101, 1'b0);
        bus.in_data   = 4'b0001;
        bus.in_parity = 1'b1;
        run_frame(4'b0101, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("b2b_gap_tx", tx, 1'b1);
        check("b2b_gap_ready", bus.in_ready, 1'b1);
        check("b2b_gap_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        run_frame(4'b0001, 1'b1, 1'b0, 10);
        idle_after();

        // Reset during data bit 2
        present(4'b1010, 1'b1);
        check("pre_rst_tx0", tx, 1'b1);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 2 * C + 2; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("postrst_tx", tx, 1'b1);
            check("postrst_done", done, 1'b0);
        end
        present(4'b1100, 1'b0);
        run_frame(4'b1100, 1'b0, 1'b0, -1);
        idle_after();

        // All-zero word exercises the stop length boundary
        present(4'b0000, 1'b0);
        run_frame(4'b0000, 1'b0, 1'b0, -1);
        idle_after();

        // Randomized words, arbitrary (possibly inconsistent) parity, mid-frame pulses
        for (int i = 0; i < 8; i++) begin
            rd = DW'($urandom);
            rp = 1'($urandom);
            present(rd, rp);
            run_frame(rd, rp, 1'b0, int'($urandom_range(2, FRAME - 3)));
            idle_after();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
